// File: rtl/snake_pkg.sv
// snake_pkg: shared state encoding and defaults for the snake game controller.
// Rev 1.0
`default_nettype none
package snake_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_WIN   = 2'd3
  } state_t;

  localparam int MAX_X             = 640;
  localparam int MAX_Y             = 480;
  localparam int DEF_WIN_SCORE     = 5;
  localparam int DEF_FRAME_DIV_MAX = 8;
  localparam int DEBOUNCE_W        = 16;
endpackage
`default_nettype wire

// File: rtl/snake_game_ctrl_btn_edge.sv
// btn_edge: 2-flop synchronizer, optional debounce (SNAKE_CTRL_DEBOUNCE_EN), rising-edge pulse.
// Rev 1.0
`default_nettype none
module btn_edge
  import snake_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_edge
);
  logic [1:0] r_sync;
  logic       r_prev;
  logic       w_level;

  always_ff @(posedge clk) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[0], i_btn};
  end

`ifdef SNAKE_CTRL_DEBOUNCE_EN
  logic [DEBOUNCE_W-1:0] r_db_cnt;
  logic                  r_db_level;

  // Counter restarts whenever the synchronized level returns to the accepted one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_db_cnt   <= '0;
      r_db_level <= 1'b0;
    end else if (r_sync[1] == r_db_level) begin
      r_db_cnt <= '0;
    end else if (&r_db_cnt) begin
      r_db_level <= r_sync[1];
      r_db_cnt   <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + 1'b1;
    end
  end
  assign w_level = r_db_level;
`else
  assign w_level = r_sync[1];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= 1'b0;
      o_edge <= 1'b0;
    end else begin
      r_prev <= w_level;
      o_edge <= w_level & ~r_prev;
    end
  end
endmodule
`default_nettype wire

// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl: move-tick divider, turn arbitration and idle/play/pause/win sequencer.
// Rev 1.0 -- button debounce enabled by defining SNAKE_CTRL_DEBOUNCE_EN.
`default_nettype none
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int WIN_SCORE       = DEF_WIN_SCORE,
  parameter int FRAME_DIV_MAX   = DEF_FRAME_DIV_MAX,
  parameter int WIN_HOLD_FRAMES = 120,
  parameter int SCORE_W         = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               btn_start,
  input  logic               btn_pause,
  input  logic               btn_r,
  input  logic               btn_l,
  input  logic [SCORE_W-1:0] score,
  output logic               move_tick,
  output logic               turn_r,
  output logic               turn_l,
  output logic               game_clr,
  output logic [1:0]         state,
  output logic               blink
);
  localparam int CW = $clog2(FRAME_DIV_MAX + 1);
  localparam int HW = $clog2(WIN_HOLD_FRAMES + 1);

  logic w_start_e, w_pause_e, w_r_e, w_l_e;
  logic [CW-1:0] w_div_m1;

  state_t        r_state;
  logic [CW-1:0] r_fcnt;
  logic [HW-1:0] r_hold;
  logic [4:0]    r_fr;
  logic          r_pend_r, r_pend_l;
  logic          r_move_tick, r_turn_r, r_turn_l, r_game_clr, r_blink;

  btn_edge u_start (.clk(clk), .rst(rst), .i_btn(btn_start), .o_edge(w_start_e));
  btn_edge u_pause (.clk(clk), .rst(rst), .i_btn(btn_pause), .o_edge(w_pause_e));
  btn_edge u_right (.clk(clk), .rst(rst), .i_btn(btn_r),     .o_edge(w_r_e));
  btn_edge u_left  (.clk(clk), .rst(rst), .i_btn(btn_l),     .o_edge(w_l_e));

  // div-1 = max(0, FRAME_DIV_MAX-1-score); saturating score keeps it non-negative.
  always_comb begin
    w_div_m1 = '0;
    if (score < SCORE_W'(FRAME_DIV_MAX - 1))
      w_div_m1 = CW'(FRAME_DIV_MAX - 1) - CW'(score);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_fcnt      <= '0;
      r_hold      <= '0;
      r_fr        <= '0;
      r_pend_r    <= 1'b0;
      r_pend_l    <= 1'b0;
      r_move_tick <= 1'b0;
      r_turn_r    <= 1'b0;
      r_turn_l    <= 1'b0;
      r_game_clr  <= 1'b0;
      r_blink     <= 1'b0;
    end else begin
      r_move_tick <= 1'b0;
      r_turn_r    <= 1'b0;
      r_turn_l    <= 1'b0;
      r_game_clr  <= 1'b0;
      if (frame_tick) r_fr <= r_fr + 1'b1;
      r_blink <= ((r_state == ST_PAUSE) || (r_state == ST_WIN)) & r_fr[4];

      case (r_state)
        ST_IDLE: begin
          r_fcnt   <= '0;
          r_pend_r <= 1'b0;
          r_pend_l <= 1'b0;
          if (w_start_e) begin
            r_game_clr <= 1'b1;
            r_state    <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          // Score still holds the old round's value while game_clr is in flight.
          if (!r_game_clr && (score >= SCORE_W'(WIN_SCORE))) begin
            r_state <= ST_WIN;
            r_hold  <= '0;
          end else if (w_pause_e) begin
            r_state <= ST_PAUSE;
          end else begin
            if (frame_tick) begin
              if (r_fcnt >= w_div_m1) begin
                r_fcnt      <= '0;
                r_move_tick <= 1'b1;
              end else begin
                r_fcnt <= r_fcnt + 1'b1;
              end
            end
            if (r_move_tick) begin
              r_turn_r <= r_pend_r;
              r_turn_l <= r_pend_l;
              r_pend_r <= 1'b0;
              r_pend_l <= 1'b0;
            end
            if (w_r_e && w_l_e) begin
              r_pend_r <= 1'b0;
              r_pend_l <= 1'b0;
            end else if (w_r_e) begin
              r_pend_r <= 1'b1;
              r_pend_l <= 1'b0;
            end else if (w_l_e) begin
              r_pend_r <= 1'b0;
              r_pend_l <= 1'b1;
            end
          end
        end
        ST_PAUSE: begin
          if (w_start_e) begin
            r_game_clr <= 1'b1;
            r_state    <= ST_PLAY;
            r_fcnt     <= '0;
            r_pend_r   <= 1'b0;
            r_pend_l   <= 1'b0;
          end else if (w_pause_e) begin
            r_state <= ST_PLAY;
          end
        end
        ST_WIN: begin
          if (w_start_e) begin
            r_game_clr <= 1'b1;
            r_state    <= ST_PLAY;
            r_fcnt     <= '0;
            r_pend_r   <= 1'b0;
            r_pend_l   <= 1'b0;
            r_hold     <= '0;
          end else if (frame_tick) begin
            if (r_hold == HW'(WIN_HOLD_FRAMES - 1)) begin
              r_game_clr <= 1'b1;
              r_state    <= ST_IDLE;
              r_hold     <= '0;
            end else begin
              r_hold <= r_hold + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign move_tick = r_move_tick;
  assign turn_r    = r_turn_r;
  assign turn_l    = r_turn_l;
  assign game_clr  = r_game_clr;
  assign state     = r_state;
  assign blink     = r_blink;
endmodule
`default_nettype wire

// File: tb/tb_snake_game_ctrl.sv
// tb_snake_game_ctrl: directed self-checking bench for snake_game_ctrl (default build).
// Rev 1.0
`default_nettype none
module tb_snake_game_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       btn_start = 1'b0, btn_pause = 1'b0, btn_r = 1'b0, btn_l = 1'b0;
  logic [3:0] score = 4'd0;
  logic       move_tick, turn_r, turn_l, game_clr, blink;
  logic [1:0] state;

  int n_tests = 0, n_fail = 0, tb_frames = 0;
  int cnt_move = 0, cnt_tr = 0, cnt_tl = 0, cnt_gclr = 0;
  int bad_lat = 0, bad_turn = 0, bad_coinc = 0;
  int m0;
  logic prev_ft = 1'b0, prev_move = 1'b0;

  // WIN_SCORE raised so the speed-scaling scores 6 and 9 stay in PLAY.
  snake_game_ctrl #(.WIN_SCORE(12), .FRAME_DIV_MAX(8), .WIN_HOLD_FRAMES(120), .SCORE_W(4)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .btn_start(btn_start), .btn_pause(btn_pause), .btn_r(btn_r), .btn_l(btn_l),
    .score(score), .move_tick(move_tick), .turn_r(turn_r), .turn_l(turn_l),
    .game_clr(game_clr), .state(state), .blink(blink)
  );

  always #5 clk = ~clk;

  // Pulse bookkeeping sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (move_tick) begin
      cnt_move++;
      if (!prev_ft) bad_lat++;
    end
    if (turn_r) begin
      cnt_tr++;
      if (!prev_move) bad_turn++;
    end
    if (turn_l) begin
      cnt_tl++;
      if (!prev_move) bad_turn++;
    end
    if (game_clr) begin
      cnt_gclr++;
      if (move_tick) bad_coinc++;
    end
    prev_ft   = frame_tick;
    prev_move = move_tick;
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step(1);
      frame_tick = 1'b0;
      tb_frames++;
      step(3);
    end
  endtask

  task automatic press(input int which);
    case (which)
      0: btn_start = 1'b1;
      1: btn_pause = 1'b1;
      2: btn_r = 1'b1;
      default: btn_l = 1'b1;
    endcase
    step(4);
    btn_start = 1'b0; btn_pause = 1'b0; btn_r = 1'b0; btn_l = 1'b0;
    step(4);
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    step(2);
    rst = 1'b0;
    step(1);
    check("rst_state", int'(state), 0);
    check("rst_outs", int'({move_tick, turn_r, turn_l, game_clr, blink}), 0);

    btn_start = 1'b1;
    step(4);
    check("start_gclr_hi", int'(game_clr), 1);
    check("start_state", int'(state), 1);
    step(1);
    check("start_gclr_lo", int'(game_clr), 0);
    btn_start = 1'b0;
    step(4);
    check("start_gclr_cnt", cnt_gclr, 1);

    frames(7);  check("div8_none", cnt_move, 0);
    frames(1);  check("div8_tick8", cnt_move, 1);
    frames(8);  check("div8_tick16", cnt_move, 2);
    frames(4);  check("div8_tick20", cnt_move, 2);
    score = 4'd6;
    frames(1);  check("div2_late", cnt_move, 3);
    frames(4);  check("div2_rate", cnt_move, 5);
    score = 4'd9;
    frames(3);  check("div1_rate", cnt_move, 8);

    score = 4'd0;
    press(2); press(2); press(2);
    check("turn_pending", cnt_tr, 0);
    frames(8);
    check("turn_r_once", cnt_tr, 1);
    check("turn_r_move", cnt_move, 9);
    press(3);
    frames(8);
    check("turn_l_once", cnt_tl, 1);
    btn_r = 1'b1; btn_l = 1'b1;
    step(4);
    btn_r = 1'b0; btn_l = 1'b0;
    step(4);
    frames(8);
    check("turn_both_r", cnt_tr, 1);
    check("turn_both_l", cnt_tl, 1);
    check("turn_after_move", bad_turn, 0);

    frames(3);
    press(1);
    check("pause_state", int'(state), 2);
    frames(10);
    check("pause_frozen", cnt_move, 11);
    check("pause_blink", int'(blink), int'(tb_frames[4]));
    press(1);
    check("resume_state", int'(state), 1);
    frames(4);  check("resume_none", cnt_move, 11);
    frames(1);  check("resume_move", cnt_move, 12);

    score = 4'd12;
    step(1);
    check("win_enter", int'(state), 3);
    frames(10);
    check("win_blink_a", int'(blink), int'(tb_frames[4]));
    frames(12);
    check("win_blink_b", int'(blink), int'(tb_frames[4]));
    frames(97);
    check("win_hold119", int'(state), 3);
    check("win_hold_gclr", cnt_gclr, 1);
    frames(1);
    check("win_exit_state", int'(state), 0);
    check("win_exit_gclr", cnt_gclr, 2);

    score = 4'd0;
    press(0);
    check("restart_state", int'(state), 1);
    score = 4'd12;
    step(1);
    check("win2_enter", int'(state), 3);
    frames(40);
    score = 4'd0;
    press(0);
    check("win_start_state", int'(state), 1);
    check("win_start_gclr", cnt_gclr, 4);

    score = 4'd12;
    step(1);
    frames(60);
    rst = 1'b1;
    step(1);
    check("rst_win_state", int'(state), 0);
    check("rst_win_outs", int'({move_tick, turn_r, turn_l, game_clr, blink}), 0);
    rst = 1'b0;
    tb_frames = 0;
    score = 4'd0;
    press(0);
    check("rst_restart", int'(state), 1);
    m0 = cnt_move;
    frames(7);  check("rst_fcnt_none", cnt_move, m0);
    frames(1);  check("rst_fcnt_move", cnt_move, m0 + 1);
    score = 4'd12;
    step(1);
    frames(119);
    check("rst_hold119", int'(state), 3);
    frames(1);
    check("rst_hold_exit", int'(state), 0);
    check("gclr_total", cnt_gclr, 6);
    check("move_latency", bad_lat, 0);
    check("gclr_move_coinc", bad_coinc, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/snake_game_ctrl.md
Name: snake_game_ctrl

Overview:
- Game sequencer that sits between the VGA timing block and the snake/food datapath.
- Converts the per-frame refresh tick into a speed-scaled move tick.
- Converts raw buttons into single-cycle turn pulses, limited to at most one turn per move.
- Runs the game FSM (idle/play/pause/win) and issues a one-cycle game-clear pulse to restart the datapath.

Parameters:
- WIN_SCORE, 5, score that ends a round (compared to score input).
- FRAME_DIV_MAX, 8, frames per move at score 0; frames per move = max(1, FRAME_DIV_MAX - score).
- WIN_HOLD_FRAMES, 120, frames spent in WIN before returning to IDLE.
- SCORE_W, 4, width of score input.

Ports:
- clk  in  1  system clock; the single clock domain.
- rst  in  1  reset, synchronous, active-high.
- frame_tick  in  1  one-clk pulse per VGA frame.
- btn_start  in  1  raw start button, asynchronous level.
- btn_pause  in  1  raw pause button, asynchronous level.
- btn_r  in  1  raw turn-right button, asynchronous level.
- btn_l  in  1  raw turn-left button, asynchronous level.
- score  in  SCORE_W  current score from the snake datapath.
- move_tick  out  1  one-clk pulse that advances the snake; drives the datapath refresh tick.
- turn_r  out  1  one-clk turn-right pulse.
- turn_l  out  1  one-clk turn-left pulse.
- game_clr  out  1  one-clk pulse that restarts the datapath: position, food, step, score.
- state  out  2  0=IDLE, 1=PLAY, 2=PAUSE, 3=WIN.
- blink  out  1  toggles every 16 frames in PAUSE/WIN; 0 in other states.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE.
  - All outputs 0.
  - Frame counter, hold counter and pending-turn flags cleared.
  - Overrides every other event, including mid-move or mid-WIN.
- Button conditioning:
  - Each button passes a 2-flop synchronizer, then a rising-edge detector.
  - An edge is a 1-clk internal pulse, 3 clk after the pad rises.
- IDLE:
  - start edge -> game_clr=1 for exactly 1 clk (the cycle after the edge is detected); next state PLAY.
  - frame counter cleared.
- PLAY:
  - On each frame_tick, the frame counter increments.
  - When the counter equals div-1, where div = max(1, FRAME_DIV_MAX - score) with score saturated at FRAME_DIV_MAX, the counter clears and move_tick=1 in the following clk (latency 1).
  - Score change mid-count: compare against the new div. If counter >= div-1 on a frame_tick, move on that tick.
- Turn arbitration (PLAY only):
  - r edge sets pend_r and clears pend_l; l edge does the opposite (latest press wins).
  - r and l edges in the same clk: both pending flags cleared.
  - In the clk after a move_tick, the pending flag produces the matching turn_r/turn_l pulse and the flag clears.
  - Result: at most one turn per move, and never in the same clk as move_tick.
  - Edges in IDLE/PAUSE/WIN are discarded.
- PAUSE:
  - In PLAY, a pause edge -> PAUSE; in PAUSE, a pause edge -> PLAY.
  - Frame counter and pending flags are frozen; no move_tick or turn pulses.
  - start edge in PAUSE -> game_clr, then PLAY (restart).
- WIN:
  - In PLAY, score >= WIN_SCORE at the clk edge -> WIN. This takes priority over a same-cycle pause edge or move.
  - Hold counter counts frame_ticks.
  - At WIN_HOLD_FRAMES: game_clr pulse, then IDLE.
  - A start edge in WIN ends the hold early with the same game_clr -> PLAY.
- game_clr: never asserted for more than 1 clk; never coincident with move_tick.
- blink: bit 4 of a free-running frame count, gated by state.

Optional Feature:
- Macro: SNAKE_CTRL_DEBOUNCE_EN.
- Defined: each synchronized button is additionally debounced. The level is accepted only after it has been stable for 2^16 clk (16-bit counter, restarts on any change), and edge detection acts on the debounced level.
- Undefined: no debounce; edges come directly from the synchronizer (3-clk latency).

Decomposition:
- Shared package snake_pkg:
  - state encoding (IDLE/PLAY/PAUSE/WIN)
  - MAX_X=640, MAX_Y=480
  - default WIN_SCORE and FRAME_DIV_MAX
  - DEBOUNCE_W=16
- Sub-module btn_edge, one instance per button: synchronizer, optional debounce, rising-edge pulse.

Test Plan:
- rst held 2 clk, then released -> state=0, all outputs 0. btn_start pulse -> game_clr high for exactly 1 clk; state=1.
- PLAY, score=0, 20 frame_ticks -> move_tick after ticks 8 and 16 (2 moves), each 1 clk after its frame_tick. Score forced to 6 -> a move every 2 frames. Score 9 -> a move every frame.
- Three btn_r presses between moves -> exactly one turn_r, 1 clk after the next move_tick. btn_r and btn_l rising in the same clk -> no turn pulse.
- Pause edge in PLAY -> 10 frame_ticks produce no move_tick. Second pause edge -> counting resumes from the frozen value.
- Score steps to 5 in PLAY -> state=3, blink toggling. After 120 frame_ticks, game_clr 1 clk, then state=0. Repeat with start pressed at frame 40 -> game_clr, then state=1.
- rst asserted in WIN at frame 60 -> next clk state=0, game_clr=0, counters cleared. With SNAKE_CTRL_DEBOUNCE_EN, a 1000-clk glitch on btn_start -> no transition.
